tlul_host_adapter: RTL
======================

# tlul_host_adapter

TL-UL host (initiator) adapter that turns a simple core-side req/gnt/rvalid memory port into `tlul_pkg::tl_h2d_t` requests and collects `tlul_pkg::tl_d2h_t` responses. It sits between a fetch unit, LSU or DMA and the crossbar or device ports, such as the SRAM-backed instruction and data memories. It tracks up to `MaxOutstanding` in-order transactions, tags them with rolling source IDs and returns read data and error status to the core.

## Interface
- `MaxOutstanding`, default 2: maximum in-flight A-channel requests. Legal range 1..8.
- `SrcW`, default 8: width of `a_source`/`d_source`; IDs use the low `$clog2(MaxOutstanding)` bits, with a minimum of 1 bit, and the upper bits are zero.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- req_i  in  1  core request; held with its fields stable until `gnt_o`.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, one per granted request.
- rdata_o  out  32  read data; 0 for writes.
- err_o  out  1  response error, qualified by `rvalid_o`.
- unexp_o  out  1  single-cycle pulse: D beat received with nothing outstanding.
- tl_h_o  out  tl_h2d_t  TL-UL A channel plus `d_ready`.
- tl_h_i  in  tl_d2h_t  TL-UL D channel plus `a_ready`.

## Operation
- `outst` counter (0..MaxOutstanding), `a_src` counter and `d_src` counter, each modulo MaxOutstanding.
- `a_valid` = `req_i` & (`outst` < MaxOutstanding) & !`loc_err_pend`.
- `a_opcode`:
  - Get (4) when `!we_i`;
  - PutFullData (0) when `we_i` & `be_i`==4'hF;
  - PutPartialData (1) otherwise.
- `a_size`=2. `a_mask` = `we_i` ? `be_i` : 4'hF. `a_address` = {`addr_i`[31:2],2'b00}. `a_data`=`wdata_i`. `a_param`=0. `a_user`=0. `a_source`=`a_src`.
- `gnt_o` = `a_valid` & `a_ready`. On grant, `a_src` increments.
- `d_ready` is held at 1.
- D beat (`d_valid`) with `outst`>0:
  - registers `rvalid_o`=1 and `rdata_o` = (`d_opcode`==AccessAckData) ? `d_data` : 0;
  - registers `err_o` = `d_error` | (`d_source` != `d_src`);
  - increments `d_src`.
- D beat with `outst`==0: dropped; `unexp_o` pulses the next cycle; no `rvalid_o`.
- `outst` update: +1 on grant only, −1 on accepted D beat only, unchanged when both occur in the same cycle.
- An `a_opcode`/`d_opcode` mismatch (read answered by AccessAck, or write answered by AccessAckData) also sets `err_o`.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `unexp_o`=0, `a_valid`=0. Counters and `loc_err_pend` clear to 0. `d_ready`=1 out of reset.
- A channel is combinational from `req_i`, so grant can occur in the same cycle as the request. Back-to-back grants are allowed every cycle while `outst` < MaxOutstanding.
- Response latency: `rvalid_o` is high exactly one cycle after the D beat. Against a 1-cycle-latency device, `rvalid_o` rises 2 cycles after `gnt_o`.
- `outst`==MaxOutstanding: `a_valid` stays low until the cycle after a D beat is accepted; no same-cycle bypass.
- Wrap: `a_src` and `d_src` wrap from MaxOutstanding−1 to 0.
- Reset while requests are in flight: all in-flight state is discarded. Late D beats arriving after reset are handled as unexpected (`unexp_o`), not as responses.
- Responses are in order only; no reordering buffer.

## Configuration
- `TLUL_HOST_ALIGN_CHECK_EN` defined:
  - A request with `addr_i`[1:0] != 0 is never issued on the A channel.
  - It is granted only when `outst`==0, which sets `loc_err_pend`.
  - The next cycle gives `rvalid_o`=1, `err_o`=1, `rdata_o`=0, and clears `loc_err_pend`.
  - While `loc_err_pend` is set, no bus request is granted.
- Macro not defined:
  - No local check; the low address bits are forced to 0 and the request is issued normally.
  - `loc_err_pend` logic is absent, and `loc_err_pend` reads constant 0.

## Test plan
- Read: `req_i`=1, `we_i`=0, `addr_i`=0x100; device returns AccessAckData, `d_data`=0xDEADBEEF, one cycle after `gnt_o` -> `a_opcode`=4, `a_mask`=4'hF; `rvalid_o`=1, `rdata_o`=0xDEADBEEF, `err_o`=0 two cycles after grant.
- Partial write: `we_i`=1, `be_i`=4'h3, `wdata_i`=0x1234 -> `a_opcode`=1, `a_mask`=4'h3; AccessAck -> `rvalid_o`=1, `rdata_o`=0, `err_o`=0.
- Throttle: `MaxOutstanding`=2, `req_i` held and `a_ready`=1, D beats delayed 5 cycles -> exactly 2 grants with `a_source` 0 then 1; third grant only the cycle after the first D beat; `a_source` wraps to 0.
- Error and ID: D beat with `d_error`=1 -> `err_o`=1. Expected source 0 but `d_source`=1 returned -> `err_o`=1. No D beat outstanding and `d_valid`=1 -> `unexp_o` pulse, `rvalid_o`=0.
- Reset mid-flight: 2 requests granted, `reset`=0 for 1 cycle, then both D beats arrive -> two `unexp_o` pulses, no `rvalid_o`, `outst` stays 0.
- With `TLUL_HOST_ALIGN_CHECK_EN`: `addr_i`=0x102 -> `a_valid` never asserts; `gnt_o`=1 then `rvalid_o`=1, `err_o`=1 next cycle. Without the macro -> `a_address`=0x100 issued on the bus.

Source files
------------

// File: rtl/tlul_host_adapter_if.sv
// TL-UL type package plus the core-side req/gnt/rvalid port bundle used by
// tlul_host_adapter. The package is kept in this file so both the interface
// and the adapter see the same bus types.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;
  localparam int TL_AUW = 16;
  localparam int TL_DUW = 16;

  // A-channel opcodes
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  // D-channel opcodes
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// Core-side memory port: request fields in, grant and one response per grant out.
interface tlul_host_adapter_if;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        unexp_o;

  // fetch unit / LSU / DMA side
  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, unexp_o
  );

  // adapter side
  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, unexp_o
  );
endinterface

// File: rtl/tlul_host_adapter.sv
// TL-UL host adapter: converts a core req/gnt/rvalid port into TL-UL A-channel
// requests, tracks up to MaxOutstanding in-order transactions with rolling
// source IDs, and returns read data / error status one cycle after each D beat.
// Optional build macro TLUL_HOST_ALIGN_CHECK_EN: misaligned requests are not
// issued on the bus but answered locally with an error response.
module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int SrcW           = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  tlul_host_adapter_if.slave   core,
  output tl_h2d_t              tl_h_o,
  input  tl_d2h_t              tl_h_i
);

  localparam int IdW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int AIW  = TL_AIW;
  localparam logic [IdW-1:0]  IdLast = IdW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0]           outst;
  logic [IdW-1:0]            a_src;
  logic [IdW-1:0]            d_src;
  logic [MaxOutstanding-1:0] pend_we;   // write flag per in-flight source slot
  logic                      loc_err_pend;
  logic                      misal;
  logic                      loc_gnt;
  logic                      a_valid;
  logic                      bus_gnt;
  logic                      d_acc;
  logic                      d_unexp;
  logic                      src_mm;
  logic                      op_mm;
  logic [2:0]                a_opcode;
  logic [SrcW-1:0]           a_src_w;
  logic [SrcW-1:0]           d_src_w;
  logic                      rvalid_q;
  logic [31:0]               rdata_q;
  logic                      err_q;
  logic                      unexp_q;
  logic                      unused_ok;

`ifdef TLUL_HOST_ALIGN_CHECK_EN
  // Misaligned requests wait for an empty pipe, then get a local error reply.
  assign misal   = core.addr_i[1:0] != 2'b00;
  assign loc_gnt = reset & core.req_i & misal & (outst == '0) & ~loc_err_pend;

  // One-cycle marker between the local grant and its error response.
  always_ff @(posedge clock) begin
    if (!reset) loc_err_pend <= 1'b0;
    else        loc_err_pend <= loc_gnt;
  end
`else
  assign misal        = 1'b0;
  assign loc_gnt      = 1'b0;
  assign loc_err_pend = 1'b0;
`endif

  // Request is offered while there is room; reset holds it off.
  assign a_valid = reset & core.req_i & (outst < CntMax) & ~loc_err_pend & ~misal;
  assign bus_gnt = a_valid & tl_h_i.a_ready;
  assign d_acc   = tl_h_i.d_valid & (outst != '0);
  assign d_unexp = tl_h_i.d_valid & (outst == '0);

  assign a_opcode = !core.we_i           ? Get :
                    (core.be_i == 4'hF)  ? PutFullData : PutPartialData;

  assign a_src_w = SrcW'(a_src);
  assign d_src_w = SrcW'(d_src);

  // Responses must come back in issue order, with the opcode matching the request.
  assign src_mm = tl_h_i.d_source != AIW'(d_src_w);
  assign op_mm  = pend_we[d_src] ? (tl_h_i.d_opcode != AccessAck)
                                 : (tl_h_i.d_opcode != AccessAckData);

  // Drive the A channel straight from the core request; D is always accepted.
  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = a_valid;
    tl_h_o.a_opcode  = a_opcode;
    tl_h_o.a_param   = 3'd0;
    tl_h_o.a_size    = 2'd2;
    tl_h_o.a_source  = AIW'(a_src_w);
    tl_h_o.a_address = {core.addr_i[31:2], 2'b00};
    tl_h_o.a_mask    = core.we_i ? core.be_i : 4'hF;
    tl_h_o.a_data    = core.wdata_i;
    tl_h_o.a_user    = '0;
    tl_h_o.d_ready   = 1'b1;
  end

  // Occupancy count and rolling A/D source IDs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      outst <= '0;
      a_src <= '0;
      d_src <= '0;
    end else begin
      if (bus_gnt) a_src <= (a_src == IdLast) ? '0 : a_src + 1'b1;
      if (d_acc)   d_src <= (d_src == IdLast) ? '0 : d_src + 1'b1;
      if (bus_gnt && !d_acc)      outst <= outst + 1'b1;
      else if (!bus_gnt && d_acc) outst <= outst - 1'b1;
    end
  end

  // Remember read/write per source slot to validate the D opcode.
  always_ff @(posedge clock) begin
    if (!reset)       pend_we <= '0;
    else if (bus_gnt) pend_we[a_src] <= core.we_i;
  end

  // Register the core response one cycle after the D beat or local error.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      unexp_q  <= 1'b0;
    end else begin
      rvalid_q <= d_acc | loc_gnt;
      unexp_q  <= d_unexp;
      if (d_acc) begin
        rdata_q <= (tl_h_i.d_opcode == AccessAckData) ? tl_h_i.d_data : 32'h0;
        err_q   <= tl_h_i.d_error | src_mm | op_mm;
      end else if (loc_gnt) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b1;
      end
    end
  end

  assign core.gnt_o    = bus_gnt | loc_gnt;
  assign core.rvalid_o = rvalid_q;
  assign core.rdata_o  = rdata_q;
  assign core.err_o    = err_q;
  assign core.unexp_o  = unexp_q;

  // D-channel fields this host has no use for.
  assign unused_ok = ^{tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink,
                       tl_h_i.d_user, core.addr_i[1:0]};

endmodule
